gf16_exp_sqm: RTL and testbench

//  Sequential GF(2^4) exponentiator: computes Z = A^E by MSB-first square-and-multiply,
//  one exponent bit per clock. Field polynomial P(x) = x^4 + x^3 + 1.

---
 rtl/gf16_pkg.sv | 28 ++
 rtl/gf16_exp_sqm_mul.sv | 24 ++
 rtl/gf16_exp_sqm.sv | 81 ++++++++
 tb/tb_gf16_exp_sqm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gf16_pkg.sv
// Shared GF(2^4) definitions: field polynomial x^4 + x^3 + 1, exponentiator states,
// and the pure squaring/reduction helpers used by the multiplier and the top.
package gf16_pkg;

   localparam logic [4:0] GF16_POLY = 5'b11001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Squaring is linear over GF(2), so it collapses to a fixed XOR network
   function automatic logic [3:0] gf16_sqr(input logic [3:0] v);
      return {v[2] ^ v[3], v[1] ^ v[3], v[3], v[0] ^ v[2] ^ v[3]};
   endfunction

   // Long division of a 7-bit carry-less product by the field polynomial, highest term first
   function automatic logic [3:0] gf16_reduce(input logic [6:0] s);
      logic [6:0] r;
      r = s;
      for (int k = 6; k >= 4; k--) begin
         if (r[k]) r = r ^ (7'(GF16_POLY) << (k - 4));
      end
      return r[3:0];
   endfunction

endpackage

// File: rtl/gf16_exp_sqm_mul.sv
// Combinational GF(2^4) multiplier: 4x4 carry-less product followed by modular reduction.
module gf16_mul
   import gf16_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [3:0] p
);

   logic [6:0] s;

   // Partial products XOR together because addition in GF(2) has no carries
   always_comb begin
      s = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s[i + j] = s[i + j] ^ (x[i] & y[j]);
         end
      end
   end

   assign p = gf16_reduce(s);

endmodule

// File: rtl/gf16_exp_sqm.sv
// Sequential GF(2^4) exponentiator: z = a^e by MSB-first square-and-multiply,
// one exponent bit per clock; busy during the EW compute cycles, done pulses once.
module gf16_exp_sqm
   import gf16_pkg::*;
#(
   parameter int EW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [3:0]    a,
   input  logic [EW-1:0] e,
   output logic          busy,
   output logic          done,
   output logic [3:0]    z
);

   localparam int CW = (EW > 1) ? $clog2(EW) : 1;

   state_t          state;
   state_t          nxt;
   logic [3:0]      acc;
   logic [3:0]      alat;
   logic [EW-1:0]   elat;
   logic [CW-1:0]   cnt;
   logic [3:0]      sq;
   logic [3:0]      prod;
   logic [3:0]      step;
   logic            accept;

   assign sq = gf16_sqr(acc);

   gf16_mul u_mul (
      .x (sq),
      .y (alat),
      .p (prod)
   );

   // A new request is taken from IDLE or straight out of DONE for back-to-back use
   assign accept = start && ((state == IDLE) || (state == DONE));
   assign step   = elat[cnt] ? prod : sq;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = RUN;
         RUN:     if (cnt == '0) nxt = DONE;
         DONE:    nxt = start ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Operands are captured on acceptance so later input changes cannot disturb a run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= 4'h1;
         alat <= 4'h0;
         elat <= '0;
         cnt  <= '0;
         z    <= 4'h0;
      end else if (accept) begin
         acc  <= 4'h1;
         alat <= a;
         elat <= e;
         cnt  <= CW'(EW - 1);
      end else if (state == RUN) begin
         acc <= step;
         cnt <= cnt - 1'b1;
         if (cnt == '0) z <= step;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_gf16_exp_sqm.sv
// Scoreboard bench for gf16_exp_sqm: expected powers from a repeated-multiplication model
// are queued at issue and checked by an independent monitor when done pulses.
module tb_gf16_exp_sqm;

   localparam int EW = 4;

   typedef struct {
      logic [3:0] zexp;
      int         due;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    a = 4'h0;
   logic [EW-1:0] e = '0;
   logic          busy;
   logic          done;
   logic [3:0]    z;

   int     checks = 0;
   int     errors = 0;
   int     ncyc = 0;
   int     runlen = 0;
   entry_t sb[$];

   gf16_exp_sqm #(.EW(EW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .e     (e),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   always #5 clk = ~clk;

   // Shift-and-add field multiply: multiply by x is a shift, folded back by the polynomial
   function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
      logic [4:0] t;
      logic [3:0] p;
      t = {1'b0, x};
      p = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (y[i]) p = p ^ t[3:0];
         t = t << 1;
         if (t[4]) t = t ^ 5'b11001;
      end
      return p;
   endfunction

   // True power by repeated multiplication, never reducing the exponent
   function automatic logic [3:0] gpow(input logic [3:0] x, input int n);
      logic [3:0] r;
      r = 4'h1;
      for (int i = 0; i < n; i++) r = gmul(r, x);
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard whenever done is seen
   always @(negedge clk) begin
      entry_t ent;
      if (rst) begin
         runlen = 0;
      end else begin
         if (busy) runlen++;
         if (done) begin
            checkOutput("busy_during_done", int'(busy), 0);
            checkOutput("busy_width", runlen, EW);
            runlen = 0;
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               ent = sb.pop_front();
               checkOutput("z", int'(z), int'(ent.zexp));
               checkOutput("latency", ncyc, ent.due);
            end
         end
      end
      ncyc++;
   end

   // Drives one cycle of inputs just after the falling edge; an issue is accepted iff not busy
   task automatic applyStimulus(input logic s, input logic [3:0] aa, input logic [EW-1:0] ee);
      entry_t ent;
      @(negedge clk);
      #1;
      start = s;
      a     = aa;
      e     = ee;
      if (s && !busy) begin
         ent.zexp = gpow(aa, int'(ee));
         ent.due  = ncyc + EW;
         sb.push_back(ent);
      end
   endtask

   // Issues one operation, then idles until the DONE cycle where z is freshly valid
   task automatic runOp(input logic [3:0] aa, input logic [EW-1:0] ee);
      int guard;
      applyStimulus(1'b1, aa, ee);
      applyStimulus(1'b0, aa, ee);
      guard = 0;
      while (busy && guard < EW + 4) begin
         applyStimulus(1'b0, 4'h0, '0);
         guard++;
      end
      if (busy) checkOutput("run_timeout", 1, 0);
   endtask

   initial begin
      logic [3:0] dz;
      int guard;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_z", int'(z), 0);
      rst = 1'b0;

      runOp(4'h2, 4'd4);
      checkOutput("a2_e4", int'(z), 'h9);
      runOp(4'h2, 4'd15);
      checkOutput("a2_e15", int'(z), 'h1);
      runOp(4'h2, 4'd14);
      checkOutput("inv_a2", int'(z), 'hC);

      runOp(4'h0, 4'd0);
      checkOutput("a0_e0", int'(z), 'h1);
      runOp(4'h0, 4'd5);
      checkOutput("a0_e5", int'(z), 'h0);
      runOp(4'h1, 4'd9);
      checkOutput("a1_e9", int'(z), 'h1);
      runOp(4'h7, 4'd1);
      checkOutput("a7_e1", int'(z), 'h7);

      for (int i = 1; i < 16; i++) begin
         runOp(4'(i), 4'd14);
         dz = z;
         checkOutput("inverse_product", int'(gmul(dz, 4'(i))), 1);
      end

      // Start pulses during RUN must be ignored
      applyStimulus(1'b1, 4'h2, 4'd4);
      applyStimulus(1'b1, 4'h5, 4'd7);
      applyStimulus(1'b1, 4'h3, 4'd2);
      applyStimulus(1'b0, 4'h6, 4'd9);
      guard = 0;
      while (busy && guard < EW + 4) begin
         applyStimulus(1'b0, 4'h0, '0);
         guard++;
      end
      checkOutput("ignored_start_z", int'(z), 'h9);

      // Asynchronous reset mid-run aborts the operation with no later done
      applyStimulus(1'b0, 4'h0, '0);
      applyStimulus(1'b1, 4'h3, 4'd6);
      applyStimulus(1'b0, 4'h0, '0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      checkOutput("abort_z", int'(z), 0);
      sb.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (EW + 3) applyStimulus(1'b0, 4'h0, '0);
      checkOutput("post_abort_busy", int'(busy), 0);

      // Start held high: back-to-back operations with inputs changing every cycle
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), EW'($urandom_range(0, 15)));
      applyStimulus(1'b0, 4'h0, '0);
      repeat (EW + 2) applyStimulus(1'b0, 4'h0, '0);

      for (int ai = 0; ai < 16; ai++) begin
         for (int ei = 0; ei < 16; ei++) runOp(4'(ai), EW'(ei));
      end

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), EW'($urandom_range(0, 15)));
      end
      applyStimulus(1'b0, 4'h0, '0);

      guard = 0;
      while (sb.size() != 0 && guard < 4 * EW + 8) begin
         applyStimulus(1'b0, 4'h0, '0);
         guard++;
      end
      checkOutput("drain_pending", sb.size(), 0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
